regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: A (ALU writeback) and B (load/debug unit).
- Round-robin arbitration with a bounded burst: under contention, the owner keeps the port for at most MAX_BURST consecutive writes before yielding.
- Registered output stage drives the register file's write-enable, write-address and write-data inputs.

Parameters:
- MAX_BURST, 2, max consecutive contended grants to one owner; legal range 1..15; stored in a 4-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  3  A target register.
- a_data  in  8  A write data.
- a_ready  out  1  A transfer accepted this cycle.
- b_valid  in  1  requester B has a write pending.
- b_addr  in  3  B target register.
- b_data  in  8  B write data.
- b_ready  out  1  B transfer accepted this cycle.
- rf_write_enable  out  1  write strobe to the register file.
- rf_write_addr  out  3  register file write address.
- rf_write_data  out  8  register file write data.
- grant_owner  out  1  current owner state: 0 = A or IDLE, 1 = B.
- conflict_count  out  8  saturating count of cycles with both requesters valid.

Behaviour:
- Reset (async, active-high): state IDLE, burst counter 0, rf_write_enable/addr/data 0, conflict_count 0, grant_owner 0. Reset takes effect immediately, not at the next edge.
- Handshake:
  - Transfer occurs when valid and ready are both high at the rising edge.
  - ready is combinational from state, counter and both valids; at most one ready is high per cycle.
  - ready is never high without its valid.
  - Requesters hold addr/data stable while valid is high and ready is low.
- Latency: exactly 1 cycle. The edge that accepts a transfer loads rf_write_addr/data with it and sets rf_write_enable=1 for one cycle.
- With no transfer, rf_write_enable=0 and addr/data hold their last values.
- States: IDLE, OWN_A, OWN_B, plus burst counter cnt.
- Arbitration, evaluated each cycle:
  - Neither valid: no grant; state and cnt unchanged. IDLE is only re-entered via reset.
  - Exactly one valid (X): grant X; state becomes OWN_X; cnt=1.
  - Both valid, state IDLE: grant A; state OWN_A; cnt=1.
  - Both valid, state OWN_X, cnt < MAX_BURST: grant X; cnt=cnt+1.
  - Both valid, state OWN_X, cnt >= MAX_BURST: grant the other requester Y; state OWN_Y; cnt=1.
- MAX_BURST=1 gives strict alternation under contention.
- conflict_count increments on every cycle with a_valid and b_valid both high, including stall cycles; saturates at 255 and never wraps.
- Same-register writes from A and B in consecutive grants are issued in grant order; the later write wins in the register file.
- Reset mid-operation: a transfer accepted on the edge before reset, whose rf write is still in the output stage, is discarded (rf_write_enable cleared). Requesters must not rely on it.
- Reset release is synchronous to clk at the integration level.

Optional Feature:
- Macro: R0_WRITE_DROP_EN.
- Defined: a transfer with addr 0 is accepted normally (ready high, arbitration, cnt and conflict_count updated) but rf_write_enable stays 0 on the following cycle; rf_write_addr/data are not updated. This keeps R0 at constant zero.
- Undefined: addr 0 writes are issued like any other address.

Test Plan:
- Reset: pulse rst mid-cycle with outputs active -> all outputs 0 immediately; with no valids afterwards, a_ready=b_ready=0 indefinitely.
- Single write: a_valid=1, a_addr=3, a_data=0x5A for one cycle -> a_ready=1 that cycle; next cycle rf_write_enable=1, addr=3, data=0x5A; cycle after, rf_write_enable=0, addr=3, data=0x5A held.
- Contention, MAX_BURST=2: both valid for 6 cycles, A data 0x11..0x16, B data 0x21..0x26 -> grant order A,A,B,B,A,A; rf_write_data 0x11,0x12,0x21,0x22,0x13,0x14; conflict_count=6.
- MAX_BURST=1: both valid for 4 cycles -> grants A,B,A,B; then only B valid for 2 cycles -> B,B with grant_owner=1.
- Saturation and reset: both valid for 300 cycles -> conflict_count=255; assert rst -> 0; after release with both valid -> A granted first.
- R0 drop: b_valid=1, b_addr=0, b_data=0xFF -> b_ready=1; with R0_WRITE_DROP_EN, rf_write_enable stays 0; without it, rf_write_enable=1, addr=0, data=0xFF.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Bundles the requester handshakes (A and B) and the register
//               file write-port outputs of regfile_write_arbiter.
//               master : requester/monitor side (drives valid/addr/data).
//               slave  : arbiter side (drives ready, rf_write_*, status).
// Signals     : a_valid/a_addr[2:0]/a_data[7:0]/a_ready  requester A
//               b_valid/b_addr[2:0]/b_data[7:0]/b_ready  requester B
//               rf_write_enable/rf_write_addr[2:0]/rf_write_data[7:0]
//               grant_owner, conflict_count[7:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
    logic       a_valid;
    logic [2:0] a_addr;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [2:0] b_addr;
    logic [7:0] b_data;
    logic       b_ready;
    logic       rf_write_enable;
    logic [2:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       grant_owner;
    logic [7:0] conflict_count;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  rf_write_enable, rf_write_addr, rf_write_data,
        input  grant_owner, conflict_count
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output rf_write_enable, rf_write_addr, rf_write_data,
        output grant_owner, conflict_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port between
//               requester A (ALU writeback) and requester B (load/debug).
//               Round-robin arbitration with a bounded burst: under
//               contention the owner keeps the port for at most MAX_BURST
//               consecutive writes. Accepted writes reach the register file
//               through a one-cycle registered output stage.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - regfile_write_arbiter_if.slave (handshakes, rf port,
//                      grant_owner, conflict_count)
// Parameters  : MAX_BURST - max consecutive contended grants (1..15)
// Option      : R0_WRITE_DROP_EN - when defined, accepted writes to address 0
//               are consumed but never strobed into the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int MAX_BURST = 2
) (
    input wire logic               clk,
    input wire logic               rst,
    regfile_write_arbiter_if.slave bus
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_OWN_A     = 2'd1;
    localparam logic [1:0] c_OWN_B     = 2'd2;
    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_both;
    logic [2:0] w_sel_addr;
    logic [7:0] w_sel_data;
    logic       w_drop;
    logic       w_issue;

    logic       r_we;
    logic [2:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_conflict;

    assign w_both = bus.a_valid && bus.b_valid;

    // ------------------------------------------------------------------
    // Arbitration: next owner, burst count and the (at most one) grant.
    // Without any valid nothing moves; IDLE is left on the first grant
    // and only comes back through reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        if (w_both) begin
            if (r_state == c_IDLE) begin
                w_grant_a   = 1'b1;
                w_state_nxt = c_OWN_A;
                w_cnt_nxt   = 4'd1;
            end else if (r_cnt < c_MAX_BURST) begin
                // owner keeps the port while its contended run is short
                w_grant_a = (r_state == c_OWN_A);
                w_grant_b = (r_state == c_OWN_B);
                w_cnt_nxt = r_cnt + 4'd1;
            end else if (r_state == c_OWN_A) begin
                w_grant_b   = 1'b1;
                w_state_nxt = c_OWN_B;
                w_cnt_nxt   = 4'd1;
            end else begin
                w_grant_a   = 1'b1;
                w_state_nxt = c_OWN_A;
                w_cnt_nxt   = 4'd1;
            end
        end else if (bus.a_valid) begin
            w_grant_a   = 1'b1;
            w_state_nxt = c_OWN_A;
            w_cnt_nxt   = 4'd1;
        end else if (bus.b_valid) begin
            w_grant_b   = 1'b1;
            w_state_nxt = c_OWN_B;
            w_cnt_nxt   = 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.a_ready = w_grant_a;
    assign bus.b_ready = w_grant_b;

    // ------------------------------------------------------------------
    // Write path selection and optional R0 suppression
    // ------------------------------------------------------------------
    assign w_sel_addr = w_grant_b ? bus.b_addr : bus.a_addr;
    assign w_sel_data = w_grant_b ? bus.b_data : bus.a_data;

`ifdef R0_WRITE_DROP_EN
    // R0 is hardwired to zero: swallow the transfer, leave the port quiet
    assign w_drop = (w_sel_addr == 3'd0);
`else
    assign w_drop = 1'b0;
`endif

    assign w_issue = (w_grant_a || w_grant_b) && !w_drop;

    // ------------------------------------------------------------------
    // Registered output stage; addr/data hold their last issued value
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= 3'd0;
            r_data <= 8'd0;
        end else begin
            r_we <= w_issue;
            if (w_issue) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    // Contention counter, saturating at 255; stall cycles count too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict <= 8'd0;
        end else if (w_both && (r_conflict != 8'hFF)) begin
            r_conflict <= r_conflict + 8'd1;
        end
    end

    assign bus.rf_write_enable = r_we;
    assign bus.rf_write_addr   = r_addr;
    assign bus.rf_write_data   = r_data;
    assign bus.grant_owner     = (r_state == c_OWN_B);
    assign bus.conflict_count  = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter. dut0 uses
//               MAX_BURST=2, dut1 uses MAX_BURST=1. Expected values come
//               from a vector table, hand sequences and a burst-run model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

`ifdef R0_WRITE_DROP_EN
    localparam bit c_DROP = 1'b1;
`else
    localparam bit c_DROP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    regfile_write_arbiter_if if0 ();
    regfile_write_arbiter_if if1 ();

    regfile_write_arbiter #(.MAX_BURST(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    regfile_write_arbiter #(.MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic drive0(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                          input logic bv, input logic [2:0] ba, input logic [7:0] bd);
        if0.a_valid = av; if0.a_addr = aa; if0.a_data = ad;
        if0.b_valid = bv; if0.b_addr = ba; if0.b_data = bd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive0(0, 0, 0, 0, 0, 0);
        if1.a_valid = 0; if1.b_valid = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       av; logic [2:0] aa; logic [7:0] ad;
        logic       bv; logic [2:0] ba; logic [7:0] bd;
        logic       ea; logic eb;
        logic       ewe; logic [2:0] eaddr; logic [7:0] edata; logic eown;
    } vec_t;

    vec_t vt[11];

    // behavioural model state for the random phase
    int         m_owner;  // 0 none, 1 A, 2 B
    int         m_run;
    int         m_cc;
    logic       m_we;
    logic [2:0] m_addr;
    logic [7:0] m_data;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive0(0, 0, 0, 0, 0, 0);
        if1.a_valid = 0; if1.a_addr = 0; if1.a_data = 0;
        if1.b_valid = 0; if1.b_addr = 0; if1.b_data = 0;

        // ---------------- reset state ----------------
        #3;
        chk("rst we", if0.rf_write_enable, 0);
        chk("rst addr", if0.rf_write_addr, 0);
        chk("rst data", if0.rf_write_data, 0);
        chk("rst owner", if0.grant_owner, 0);
        chk("rst cc", if0.conflict_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- vector table ----------------
        vt[0]  = '{1,1,8'h11, 1,2,8'h21, 1,0, 1,1,8'h11,0};
        vt[1]  = '{1,1,8'h12, 1,2,8'h21, 1,0, 1,1,8'h12,0};
        vt[2]  = '{1,1,8'h13, 1,2,8'h21, 0,1, 1,2,8'h21,1};
        vt[3]  = '{1,1,8'h13, 1,2,8'h22, 0,1, 1,2,8'h22,1};
        vt[4]  = '{1,1,8'h13, 1,2,8'h23, 1,0, 1,1,8'h13,0};
        vt[5]  = '{1,1,8'h14, 1,2,8'h23, 1,0, 1,1,8'h14,0};
        vt[6]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,1,8'h14,0};
        vt[7]  = '{1,3,8'h5A, 0,0,8'h00, 1,0, 1,3,8'h5A,0};
        vt[8]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,3,8'h5A,0};
        vt[9]  = c_DROP ? '{0,0,8'h00, 1,0,8'hFF, 0,1, 0,3,8'h5A,1}
                        : '{0,0,8'h00, 1,0,8'hFF, 0,1, 1,0,8'hFF,1};
        vt[10] = c_DROP ? '{0,0,8'h00, 0,0,8'h00, 0,0, 0,3,8'h5A,1}
                        : '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0,8'hFF,1};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive0(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd);
            #1;
            chk($sformatf("vec%0d a_ready", i), if0.a_ready, vt[i].ea);
            chk($sformatf("vec%0d b_ready", i), if0.b_ready, vt[i].eb);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d we", i), if0.rf_write_enable, vt[i].ewe);
            chk($sformatf("vec%0d addr", i), if0.rf_write_addr, vt[i].eaddr);
            chk($sformatf("vec%0d data", i), if0.rf_write_data, vt[i].edata);
            chk($sformatf("vec%0d owner", i), if0.grant_owner, vt[i].eown);
        end
        chk("table cc", if0.conflict_count, 6);

        // ---------------- asynchronous reset mid-cycle ----------------
        @(negedge clk);
        drive0(0, 0, 0, 1, 5, 8'h77);
        @(posedge clk);
        #1;
        drive0(0, 0, 0, 0, 0, 0);
        chk("pre-rst we", if0.rf_write_enable, 1);
        chk("pre-rst owner", if0.grant_owner, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst we", if0.rf_write_enable, 0);
        chk("async rst addr", if0.rf_write_addr, 0);
        chk("async rst data", if0.rf_write_data, 0);
        chk("async rst owner", if0.grant_owner, 0);
        chk("async rst cc", if0.conflict_count, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("idle a_ready", if0.a_ready, 0);
            chk("idle b_ready", if0.b_ready, 0);
        end

        // ---------------- MAX_BURST=1 alternation (dut1) ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if1.a_valid = (i < 4);
            if1.b_valid = 1'b1;
            if1.a_addr = 3'd1; if1.a_data = 8'(8'h40 + i);
            if1.b_addr = 3'd2; if1.b_data = 8'(8'h50 + i);
            #1;
            chk($sformatf("mb1 c%0d a_ready", i), if1.a_ready, (i < 4) && (i % 2 == 0));
            chk($sformatf("mb1 c%0d b_ready", i), if1.b_ready, !((i < 4) && (i % 2 == 0)));
        end
        @(posedge clk);
        #1;
        chk("mb1 owner", if1.grant_owner, 1);
        @(negedge clk);
        if1.a_valid = 0; if1.b_valid = 0;

        // ---------------- saturation then reset ----------------
        do_reset();
        @(negedge clk);
        drive0(1, 1, 8'h01, 1, 2, 8'h02);
        repeat (300) @(posedge clk);
        #1;
        chk("sat cc", if0.conflict_count, 255);
        rst = 1'b1;
        #1;
        chk("sat rst cc", if0.conflict_count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst a_ready", if0.a_ready, 1);
        chk("post-rst b_ready", if0.b_ready, 0);

        // ---------------- randomized vs model ----------------
        do_reset();
        m_owner = 0; m_run = 0; m_cc = 0;
        m_we = 0; m_addr = 0; m_data = 0;
        begin
            logic pa, pb, ga, gb, av, bv, ex_drop;
            logic [2:0] aa, ba;
            logic [7:0] ad, bd;
            int gnt;
            pa = 0; pb = 0; aa = 0; ba = 0; ad = 0; bd = 0; av = 0; bv = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                // an unserved request stays put with stable payload
                if (!pa) begin
                    av = ($urandom_range(3) != 0);
                    aa = 3'($urandom_range(7)); ad = 8'($urandom);
                end
                if (!pb) begin
                    bv = ($urandom_range(3) != 0);
                    ba = 3'($urandom_range(7)); bd = 8'($urandom);
                end
                drive0(av, aa, ad, bv, ba, bd);
                // who wins: the current owner continues a contended run
                // until it has had MAX_BURST writes, then the other one
                gnt = 0;
                if (av && bv) begin
                    if (m_owner == 0) gnt = 1;
                    else if (m_run < 2) gnt = m_owner;
                    else gnt = 3 - m_owner;
                end else if (av) gnt = 1;
                else if (bv) gnt = 2;
                ga = (gnt == 1); gb = (gnt == 2);
                #1;
                chk("rnd a_ready", if0.a_ready, ga);
                chk("rnd b_ready", if0.b_ready, gb);
                if (av && bv && m_cc < 255) m_cc++;
                if (gnt != 0) begin
                    if (av && bv && gnt == m_owner) m_run++;
                    else m_run = 1;
                    m_owner = gnt;
                    ex_drop = c_DROP && (((gnt == 1) ? aa : ba) == 3'd0);
                    m_we = !ex_drop;
                    if (!ex_drop) begin
                        m_addr = (gnt == 1) ? aa : ba;
                        m_data = (gnt == 1) ? ad : bd;
                    end
                end else begin
                    m_we = 0;
                end
                pa = av && !ga;
                pb = bv && !gb;
                if (ga) av = 0;
                if (gb) bv = 0;
                @(posedge clk);
                #1;
                chk("rnd we", if0.rf_write_enable, m_we);
                chk("rnd addr", if0.rf_write_addr, m_addr);
                chk("rnd data", if0.rf_write_data, m_data);
                chk("rnd owner", if0.grant_owner, m_owner == 2);
                chk("rnd cc", if0.conflict_count, m_cc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
